inst_fetch_queue: RTL and testbench

//  Fetch stage between InstMem and the decode/execute datapath. Owns the fetch PC,

---
 rtl/inst_fetch_queue_if.sv | 46 ++++
 rtl/inst_fetch_queue.sv | 105 ++++++++++
 tb/tb_inst_fetch_queue.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/inst_fetch_queue_if.sv
// Signal bundle joining the fetch queue to instruction memory, the redirect
// source and the decode stage. "master" is the fetch queue, "slave" its surroundings.
interface inst_fetch_queue_if #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_rdata;
   logic              redirect;
   logic [ADDR_W-1:0] redirect_pc;
   logic              inst_valid;
   logic              inst_ready;
   logic [DATA_W-1:0] inst_out;
   logic [ADDR_W-1:0] inst_pc;
   logic [CNT_W-1:0]  count;

   modport master (
      output mem_req,
      output mem_addr,
      input  mem_rdata,
      input  redirect,
      input  redirect_pc,
      output inst_valid,
      input  inst_ready,
      output inst_out,
      output inst_pc,
      output count
   );

   modport slave (
      input  mem_req,
      input  mem_addr,
      output mem_rdata,
      output redirect,
      output redirect_pc,
      input  inst_valid,
      output inst_ready,
      input  inst_out,
      input  inst_pc,
      input  count
   );
endinterface

// File: rtl/inst_fetch_queue.sv
// Fetch stage: owns the fetch PC, issues 1-cycle-latency InstMem reads and buffers
// the returned {pc, instruction} pairs in a small FIFO with a valid/ready output.
module inst_fetch_queue #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   inst_fetch_queue_if.master  bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W:0]    DEPTH_C  = (CNT_W+1)'(DEPTH);
   localparam logic [DATA_W-1:0] NOP_INSN = DATA_W'(32'h0000_0013);

   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic              pend_q, pend_d;
   logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;

   logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
   logic [DATA_W-1:0] data_mem_q [DEPTH];

   logic              issue;
   logic              push;
   logic              pop;
   logic              head_valid;
   logic [CNT_W:0]    credit_used;

   // Outstanding request counts as an occupied slot, so a returning word always fits.
   assign credit_used = {1'b0, count_q} + {{CNT_W{1'b0}}, pend_q};
   assign issue       = !rst && !bus.redirect && (credit_used < DEPTH_C);
   assign push        = !rst && !bus.redirect && pend_q;
   assign head_valid  = !rst && (count_q != '0);
   assign pop         = head_valid && bus.inst_ready;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      pend_d     = issue;
      pend_pc_d  = pend_pc_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;

      if (issue) begin
         pend_pc_d  = fetch_pc_q;
         fetch_pc_d = fetch_pc_q + ADDR_W'(4);
      end
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      // A redirect discards everything buffered or in flight and restarts aligned.
      if (bus.redirect) begin
         fetch_pc_d = bus.redirect_pc & ~ADDR_W'(3);
         pend_d     = 1'b0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q <= '0;
         pend_q     <= 1'b0;
         pend_pc_q  <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         pend_q     <= pend_d;
         pend_pc_q  <= pend_pc_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem_q[wr_ptr_q]   <= pend_pc_q;
         data_mem_q[wr_ptr_q] <= bus.mem_rdata;
      end
   end

   assign bus.mem_req    = issue;
   assign bus.mem_addr   = fetch_pc_q;
   assign bus.inst_valid = head_valid;
   assign bus.inst_out   = head_valid ? data_mem_q[rd_ptr_q] : NOP_INSN;
   assign bus.inst_pc    = head_valid ? pc_mem_q[rd_ptr_q] : '0;
   assign bus.count      = count_q;
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed cycle-by-cycle vectors for inst_fetch_queue; InstMem model returns addr+1.
module tb_inst_fetch_queue;
   localparam int DEPTH  = 4;
   localparam int ADDR_W = 8;
   localparam int DATA_W = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   inst_fetch_queue_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   inst_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   // InstMem: word at byte address A is A+1; unrequested cycles return junk.
   always @(posedge clk) begin
      bus.mem_rdata <= bus.mem_req ? ({24'h0, bus.mem_addr} + 32'd1) : 32'hDEAD_BEEF;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // One clock cycle: apply inputs after the edge, let them settle, then compare.
   // cnt < 0 skips the count comparison.
   task automatic step(input string tag, input logic r, input logic redir,
                       input logic [7:0] rpc, input logic rdy,
                       input logic req, input logic [7:0] addr,
                       input logic vld, input logic [7:0] pc, input int cnt);
      @(posedge clk);
      #1;
      rst             = r;
      bus.redirect    = redir;
      bus.redirect_pc = rpc;
      bus.inst_ready  = rdy;
      #1;
      $display("%s rst=%0b redir=%0b rdy=%0b req=%0b addr=%02h valid=%0b pc=%02h inst=%08h count=%0d",
               tag, r, redir, rdy, bus.mem_req, bus.mem_addr, bus.inst_valid,
               bus.inst_pc, bus.inst_out, bus.count);
      check({tag, ".req"}, {31'd0, bus.mem_req}, {31'd0, req});
      if (req) check({tag, ".addr"}, {24'd0, bus.mem_addr}, {24'd0, addr});
      check({tag, ".valid"}, {31'd0, bus.inst_valid}, {31'd0, vld});
      check({tag, ".pc"}, {24'd0, bus.inst_pc}, vld ? {24'd0, pc} : 32'd0);
      check({tag, ".inst"}, bus.inst_out, vld ? ({24'd0, pc} + 32'd1) : 32'h0000_0013);
      if (cnt >= 0) check({tag, ".count"}, {29'd0, bus.count}, cnt);
   endtask

   // Two reset cycles; the second sees the post-reset state.
   task automatic do_reset(input string tag);
      step({tag, ".rst0"}, 1, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, -1);
      step({tag, ".rst1"}, 1, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0);
   endtask

   // Fill from reset with inst_ready low: four requests, then count saturates.
   task automatic fill_to_full(input string tag);
      step({tag, ".c0"}, 0, 0, 8'h00, 0, 1, 8'h00, 0, 8'h00, 0);
      step({tag, ".c1"}, 0, 0, 8'h00, 0, 1, 8'h04, 0, 8'h00, 0);
      step({tag, ".c2"}, 0, 0, 8'h00, 0, 1, 8'h08, 1, 8'h00, 1);
      step({tag, ".c3"}, 0, 0, 8'h00, 0, 1, 8'h0C, 1, 8'h00, 2);
      step({tag, ".c4"}, 0, 0, 8'h00, 0, 0, 8'h00, 1, 8'h00, 3);
      step({tag, ".c5"}, 0, 0, 8'h00, 0, 0, 8'h00, 1, 8'h00, 4);
      step({tag, ".c6"}, 0, 0, 8'h00, 0, 0, 8'h00, 1, 8'h00, 4);
      step({tag, ".c7"}, 0, 0, 8'h00, 0, 0, 8'h00, 1, 8'h00, 4);
   endtask

   initial begin
      bus.redirect    = 1'b0;
      bus.redirect_pc = '0;
      bus.inst_ready  = 1'b0;

      // Streaming from reset with ready high, then back-to-back redirects.
      do_reset("t1");
      for (int k = 0; k < 8; k++) begin
         step($sformatf("t1.c%0d", k), 0, 0, 8'h00, 1, 1, 8'(4 * k),
              k >= 2, 8'(4 * (k - 2)), (k >= 2) ? 1 : 0);
      end
      step("t1.redirA", 0, 1, 8'h80, 1, 0, 8'h00, 1, 8'h18, 1);
      step("t1.redirB", 0, 1, 8'h21, 1, 0, 8'h00, 0, 8'h00, 0);
      step("t1.r1",     0, 0, 8'h00, 1, 1, 8'h20, 0, 8'h00, 0);
      step("t1.r2",     0, 0, 8'h00, 1, 1, 8'h24, 0, 8'h00, 0);
      step("t1.r3",     0, 0, 8'h00, 1, 1, 8'h28, 1, 8'h20, 1);
      step("t1.r4",     0, 0, 8'h00, 1, 1, 8'h2C, 1, 8'h24, 1);

      // Stall to full, then drain in order.
      do_reset("t2");
      fill_to_full("t2");
      step("t2.c8",  0, 0, 8'h00, 1, 0, 8'h00, 1, 8'h00, 4);
      step("t2.c9",  0, 0, 8'h00, 1, 1, 8'h10, 1, 8'h04, 3);
      step("t2.c10", 0, 0, 8'h00, 1, 1, 8'h14, 1, 8'h08, 2);
      step("t2.c11", 0, 0, 8'h00, 1, 1, 8'h18, 1, 8'h0C, 2);
      step("t2.c12", 0, 0, 8'h00, 1, 1, 8'h1C, 1, 8'h10, 2);

      // Redirect to an unaligned target with count=3 and a response in flight.
      do_reset("t3");
      step("t3.c0", 0, 0, 8'h00, 0, 1, 8'h00, 0, 8'h00, 0);
      step("t3.c1", 0, 0, 8'h00, 0, 1, 8'h04, 0, 8'h00, 0);
      step("t3.c2", 0, 0, 8'h00, 0, 1, 8'h08, 1, 8'h00, 1);
      step("t3.c3", 0, 0, 8'h00, 0, 1, 8'h0C, 1, 8'h00, 2);
      step("t3.c4", 0, 1, 8'h43, 0, 0, 8'h00, 1, 8'h00, 3);
      step("t3.c5", 0, 0, 8'h00, 1, 1, 8'h40, 0, 8'h00, 0);
      step("t3.c6", 0, 0, 8'h00, 1, 1, 8'h44, 0, 8'h00, 0);
      step("t3.c7", 0, 0, 8'h00, 1, 1, 8'h48, 1, 8'h40, 1);
      step("t3.c8", 0, 0, 8'h00, 1, 1, 8'h4C, 1, 8'h44, 1);

      // Address wrap-around from 0xF8.
      step("t4.c0", 0, 1, 8'hF8, 1, 0, 8'h00, 1, 8'h48, 1);
      step("t4.c1", 0, 0, 8'h00, 1, 1, 8'hF8, 0, 8'h00, 0);
      step("t4.c2", 0, 0, 8'h00, 1, 1, 8'hFC, 0, 8'h00, 0);
      step("t4.c3", 0, 0, 8'h00, 1, 1, 8'h00, 1, 8'hF8, 1);
      step("t4.c4", 0, 0, 8'h00, 1, 1, 8'h04, 1, 8'hFC, 1);
      step("t4.c5", 0, 0, 8'h00, 1, 1, 8'h08, 1, 8'h00, 1);
      step("t4.c6", 0, 0, 8'h00, 1, 1, 8'h0C, 1, 8'h04, 1);

      // Full FIFO, a single pop, and the refill it enables.
      do_reset("t5");
      fill_to_full("t5");
      step("t5.c8",  0, 0, 8'h00, 1, 0, 8'h00, 1, 8'h00, 4);
      step("t5.c9",  0, 0, 8'h00, 0, 1, 8'h10, 1, 8'h04, 3);
      step("t5.c10", 0, 0, 8'h00, 0, 0, 8'h00, 1, 8'h04, 3);
      step("t5.c11", 0, 0, 8'h00, 0, 0, 8'h00, 1, 8'h04, 4);
      step("t5.c12", 0, 0, 8'h00, 1, 0, 8'h00, 1, 8'h04, 4);
      step("t5.c13", 0, 0, 8'h00, 1, 1, 8'h14, 1, 8'h08, 3);

      // Reset mid-stream at count=2 together with a redirect: reset wins.
      do_reset("t6");
      step("t6.c0", 0, 0, 8'h00, 0, 1, 8'h00, 0, 8'h00, 0);
      step("t6.c1", 0, 0, 8'h00, 0, 1, 8'h04, 0, 8'h00, 0);
      step("t6.c2", 0, 0, 8'h00, 0, 1, 8'h08, 1, 8'h00, 1);
      step("t6.c3", 1, 1, 8'h80, 0, 0, 8'h00, 0, 8'h00, 2);
      step("t6.c4", 0, 0, 8'h00, 1, 1, 8'h00, 0, 8'h00, 0);
      step("t6.c5", 0, 0, 8'h00, 1, 1, 8'h04, 0, 8'h00, 0);
      step("t6.c6", 0, 0, 8'h00, 1, 1, 8'h08, 1, 8'h00, 1);
      step("t6.c7", 0, 0, 8'h00, 1, 1, 8'h0C, 1, 8'h04, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
